register_file_mp: RTL and testbench



---
 rtl/register_file_mp.sv | 103 ++++++++++
 tb/tb_register_file_mp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file: RD_PORTS registered read ports, two active-low write ports, built-in clear sequencer.
// Optional same-cycle write-to-read bypass enabled by `define REGISTER_FILE_MP_BYPASS_EN.
module register_file_mp #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SIZE     = 8,
  parameter int unsigned RD_PORTS = 3
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       clr,
  output logic                       ready,
  input  logic [RD_PORTS*SIZE-1:0]   rd_address,
  output logic [RD_PORTS*WIDTH-1:0]  rd_data,
  input  logic [SIZE-1:0]            wr_address1,
  input  logic [SIZE-1:0]            wr_address2,
  input  logic [WIDTH-1:0]           wr_data1,
  input  logic [WIDTH-1:0]           wr_data2,
  input  logic                       wr1,
  input  logic                       wr2
);

  localparam int unsigned DEPTH = 32'(1) << SIZE;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                     state, state_nxt;
  logic [SIZE-1:0]            cnt, cnt_nxt;
  logic                       ready_nxt;
  logic [RD_PORTS*WIDTH-1:0]  rd_nxt;
  logic                       we1, we2, wec;
  logic [WIDTH-1:0]           mem [DEPTH];

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready   <= 1'b0;
      rd_data <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready   <= ready_nxt;
      rd_data <= rd_nxt;
    end
  end

  // Next-state, counter and write-enable decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = 1'b0;
    we1       = 1'b0;
    we2       = 1'b0;
    wec       = 1'b0;
    case (state)
      CLEAR: begin
        wec     = 1'b1;
        cnt_nxt = cnt + SIZE'(1);
        if (cnt == '1) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN: begin
        we1       = !wr1;
        // Port 1 wins an address collision, so port 2 is simply suppressed
        we2       = !wr2 && !(!wr1 && (wr_address1 == wr_address2));
        ready_nxt = 1'b1;
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          ready_nxt = 1'b0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Read ports; held at zero while clearing
  always_comb begin
    rd_nxt = '0;
    if (state == RUN) begin
      for (int k = 0; k < RD_PORTS; k++) begin
        rd_nxt[k*WIDTH +: WIDTH] = mem[rd_address[k*SIZE +: SIZE]];
`ifdef REGISTER_FILE_MP_BYPASS_EN
        if (we2 && (wr_address2 == rd_address[k*SIZE +: SIZE]))
          rd_nxt[k*WIDTH +: WIDTH] = wr_data2;
        if (we1 && (wr_address1 == rd_address[k*SIZE +: SIZE]))
          rd_nxt[k*WIDTH +: WIDTH] = wr_data1;
`endif
      end
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wec) mem[cnt] <= '0;
    if (we2) mem[wr_address2] <= wr_data2;
    if (we1) mem[wr_address1] <= wr_data1;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised scoreboard bench for register_file_mp (SIZE=4, 3 read ports) with a behavioural model.
// Honours `define REGISTER_FILE_MP_BYPASS_EN in its expectations.
module tb_register_file_mp;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;
  localparam int unsigned P = 3;
  localparam int unsigned D = 16;

  logic             clk = 1'b0;
  logic             nreset;
  logic             clr;
  logic             ready;
  logic [P*S-1:0]   rd_address;
  logic [P*W-1:0]   rd_data;
  logic [S-1:0]     wr_address1, wr_address2;
  logic [W-1:0]     wr_data1, wr_data2;
  logic             wr1, wr2;

  register_file_mp #(.WIDTH(W), .SIZE(S), .RD_PORTS(P)) dut (
    .clk(clk), .nreset(nreset), .clr(clr), .ready(ready),
    .rd_address(rd_address), .rd_data(rd_data),
    .wr_address1(wr_address1), .wr_address2(wr_address2),
    .wr_data1(wr_data1), .wr_data2(wr_data2),
    .wr1(wr1), .wr2(wr2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             target;
    logic           rdy;
    logic [P*W-1:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [W-1:0] mm [D];
  int          clr_left;

  always @(posedge clk) edge_cnt++;

  // Monitor: compare outputs after each edge with queued expectations
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].target <= edge_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (e.target != edge_cnt || ready !== e.rdy) begin
        bad++;
        $display("FAIL ready edge=%0d target=%0d got %b want %b", edge_cnt, e.target, ready, e.rdy);
      end
      total++;
      if (rd_data !== e.rd) begin
        bad++;
        $display("FAIL rd_data edge=%0d got %h want %h", edge_cnt, rd_data, e.rd);
      end
    end
  end

  // Drive one cycle and record what the file must present after the next edge
  task automatic step(input logic c, input logic w1, input logic [S-1:0] a1, input logic [W-1:0] d1,
                      input logic w2, input logic [S-1:0] a2, input logic [W-1:0] d2,
                      input logic [P*S-1:0] ra);
    exp_t e;
    clr = c; wr1 = w1; wr_address1 = a1; wr_data1 = d1;
    wr2 = w2; wr_address2 = a2; wr_data2 = d2; rd_address = ra;
    e.target = edge_cnt + 1;
    e.rd = '0;
    if (clr_left > 0) begin
      mm[D - clr_left] = '0;
      clr_left--;
      e.rdy = (clr_left == 0);
    end else begin
      for (int k = 0; k < P; k++) begin
        logic [S-1:0] a;
        logic [W-1:0] v;
        a = ra[k*S +: S];
        v = mm[a];
`ifdef REGISTER_FILE_MP_BYPASS_EN
        if (!w1 && a1 == a) v = d1;
        else if (!w2 && a2 == a) v = d2;
`endif
        e.rd[k*W +: W] = v;
      end
      if (!w2) mm[a2] = d2;
      if (!w1) mm[a1] = d1;
      e.rdy = !c;
      if (c) clr_left = D;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [P*S-1:0] ra);
    step(1'b0, 1'b1, '0, '0, 1'b1, '0, '0, ra);
  endtask

  task automatic rand_step(input bit allow_clr, input bit writes);
    logic c;
    logic [P*S-1:0] ra;
    c = allow_clr && ($urandom_range(0, 39) == 0);
    ra = P*S'($urandom);
    step(c, writes ? 1'($urandom) : 1'b1, S'($urandom), W'($urandom),
         writes ? 1'($urandom) : 1'b1, S'($urandom), W'($urandom), ra);
  endtask

  task automatic read_all();
    for (int i = 0; i < D; i++)
      idle({S'(i + 2), S'(i + 1), S'(i)});
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately
  task automatic pulse_reset();
    nreset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL async_ready got %b want 0", ready);
    end
    total++;
    if (rd_data !== '0) begin
      bad++;
      $display("FAIL async_rd_data got %h want 0", rd_data);
    end
    clr_left = D;
    #1;
    nreset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    nreset = 1'b0; clr = 1'b0; wr1 = 1'b1; wr2 = 1'b1;
    wr_address1 = '0; wr_address2 = '0; wr_data1 = '0; wr_data2 = '0; rd_address = '0;
    repeat (2) @(posedge clk);
    #2;
    pulse_reset();

    // Clear after reset, with writes offered that must be ignored
    for (int i = 0; i < D; i++) rand_step(1'b0, 1'b1);
    read_all();

    // Write then read on port 2 (index 1)
    step(1'b0, 1'b0, S'(5), 16'h1234, 1'b1, '0, '0, '0);
    idle({S'(0), S'(5), S'(0)});

    // Same-address collision: port 1 wins
    step(1'b0, 1'b0, S'(3), 16'hAAAA, 1'b0, S'(3), 16'h5555, '0);
    idle({S'(3), S'(3), S'(3)});

    // Same-cycle write and read of one address
    step(1'b0, 1'b1, '0, '0, 1'b0, S'(7), 16'h0001, '0);
    step(1'b0, 1'b0, S'(7), 16'hBEEF, 1'b1, '0, '0, {S'(7), S'(7), S'(7)});
    idle({S'(7), S'(7), S'(7)});

    // Random traffic with occasional clear requests
    for (int i = 0; i < 300; i++) rand_step(1'b1, 1'b1);
    while (clr_left > 0) rand_step(1'b0, 1'b1);

    // Fill non-zero, clear, ignored writes during clear, then read back zeros
    for (int i = 0; i < D; i++)
      step(1'b0, 1'b0, S'(i), W'(16'h0100 + i), 1'b1, '0, '0, '0);
    step(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, '0);
    for (int i = 0; i < D; i++)
      step(1'b1, 1'b0, S'(i), 16'hFFFF, 1'b0, S'(D - 1 - i), 16'h7777, '0);
    read_all();

    // Reset in the middle of a clear at counter 9
    for (int i = 0; i < D; i++)
      step(1'b0, 1'b0, S'(i), W'(16'h0A00 + i), 1'b1, '0, '0, '0);
    step(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, '0);
    for (int i = 0; i < 9; i++) idle('0);
    pulse_reset();
    for (int i = 0; i < D + 2; i++) rand_step(1'b0, 1'b0);
    read_all();

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
